dmem_arbiter: RTL

- Shares the single-port data memory between the pipeline MEM stage (CPU port) and a read-only debug port used by the LCD/display logic to inspect memory words.
- The CPU has priority. A pending debug read is served as soon as the CPU port is idle, or forcibly after MAX_WAIT consecutive cycles of CPU traffic.
- While the debug read occupies the memory, the block stalls the pipeline through cpu_stall.
- It sits between the MEM-stage memory signals and the data memory instance, and counts stall cycles for on-screen display.

---
 rtl/dmem_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: the MEM-stage CPU port has priority, and a read-only debug port
// is granted when the CPU is idle or after MAX_WAIT busy cycles, stalling the pipeline.
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        S_CPU,
        S_DBG_ISSUE,
        S_DBG_DATA,
        S_DBG_ACK
    } state_t;

    state_t            state, state_next;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_next;
    logic [ADDR_W-1:0] dbg_addr_q;
    logic              go;

    assign cpu_rdata = mem_rdata;

    // NOTE: every output of this block gets a default before the case statement,
    // so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        mem_addr      = cpu_addr;
        mem_wdata     = cpu_wdata;
        mem_we        = cpu_req & cpu_we;
        cpu_stall     = 1'b0;
        go            = dbg_req & (~cpu_req | (wait_cnt == WAIT_W'(MAX_WAIT)));

        case (state)
            S_CPU: begin
                if (go) begin
                    state_next    = S_DBG_ISSUE;
                    wait_cnt_next = '0;
                end else if (dbg_req && cpu_req) begin
                    wait_cnt_next = wait_cnt + 1'b1;
                end else begin
                    wait_cnt_next = '0;
                end
            end
            S_DBG_ISSUE: begin
                mem_addr   = dbg_addr_q;
                mem_we     = 1'b0;
                cpu_stall  = 1'b1;
                state_next = S_DBG_DATA;
            end
            S_DBG_DATA: begin
                mem_addr   = dbg_addr_q;
                mem_we     = 1'b0;
                cpu_stall  = 1'b1;
                state_next = S_DBG_ACK;
            end
            // dbg_req is still high here while the requester sees the ack; ignore it.
            S_DBG_ACK: state_next = S_CPU;
            default:   state_next = S_CPU;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_CPU;
            wait_cnt   <= '0;
            dbg_addr_q <= '0;
            dbg_rdata  <= '0;
            dbg_ack    <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            dbg_ack  <= (state == S_DBG_DATA);
            if (state == S_CPU && go) begin
                dbg_addr_q <= dbg_addr;
            end
            if (state == S_DBG_DATA) begin
                dbg_rdata <= mem_rdata;
            end
            // Saturates rather than wraps so the display never shows a misleading small value.
            if (cpu_stall && stall_cnt != {CNT_W{1'b1}}) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule
